// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches sequential 16-bit words from imem and buffers them for the ID stage.
// Latency: a word requested in cycle n is pushed at the edge ending cycle n+L, visible on out_ir in cycle n+L+1.
// Backpressure: requests stop while the FIFO would be full; at most one memory request is outstanding.
//
// Ports:
//   clock, reset          - single clock (state updates on the falling edge), synchronous active-high reset
//   imem_req/imem_addr    - one-cycle request strobe and byte address of the requested word
//   imem_data/imem_valid  - returned instruction word and its strobe (L >= 1 cycles after the request)
//   redirect/redirect_pc  - taken branch: flush and refetch from redirect_pc (bit 0 forced to 0)
//   deq                   - ID stage consumes the head entry this cycle
//   out_ir/out_pcplus2    - head instruction and its PC+2, both 0 when empty (nop bubble)
//   out_valid/count       - queue non-empty flag and number of valid entries
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clock,
    input  logic          reset,
    output logic          imem_req,
    output logic [15:0]   imem_addr,
    input  logic [15:0]   imem_data,
    input  logic          imem_valid,
    input  logic          redirect,
    input  logic [15:0]   redirect_pc,
    input  logic          deq,
    output logic [15:0]   out_ir,
    output logic [15:0]   out_pcplus2,
    output logic          out_valid,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [15:0]   r_fpc;
    logic [15:0]   r_ir  [DEPTH];
    logic [15:0]   r_pc2 [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [15:0]   w_target;
    logic [15:0]   w_fpc_inc;
    logic          w_push;
    logic          w_pop;
    logic          w_nonempty;
    logic          w_req;
    logic [CW-1:0] w_count_nxt;

    // Masking keeps every redirect_pc bit in use while clearing bit 0.
    assign w_target    = redirect_pc & 16'hFFFE;
    assign w_fpc_inc   = r_fpc + 16'd2;
    assign w_nonempty  = (r_count != '0);

    // Redirect overrides both push and deq: the flush wins.
    assign w_push      = (r_state == S_WAIT) && imem_valid && !redirect;
    assign w_pop       = deq && w_nonempty && !redirect;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Any imem_valid seen here is a leftover from before reset; ignore it.
                if (!redirect && (r_count < CW'(DEPTH))) begin
                    w_req       = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    // Response still in flight must be swallowed once it shows up.
                    w_state_nxt = imem_valid ? S_IDLE : S_DROP;
                end else if (imem_valid) begin
                    // Back-to-back issue decision uses the post-push/post-deq occupancy.
                    if (w_count_nxt < CW'(DEPTH)) begin
                        w_req = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                // The stale response ends the drop even if a redirect lands in the same
                // cycle; waiting for a second response would never complete.
                if (imem_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign imem_req  = w_req && !reset;
    // A back-to-back request targets the word after the one just returned.
    assign imem_addr = w_push ? w_fpc_inc : r_fpc;

    always_ff @(negedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_fpc   <= 16'h0000;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect) begin
                r_fpc   <= w_target;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_fpc  <= w_fpc_inc;
                    r_tail <= r_tail + PW'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + PW'(1);
                end
                r_count <= w_count_nxt;
            end
        end
    end

    // Entry storage needs no reset: the outputs are gated by count.
    always_ff @(negedge clock) begin
        if (w_push && !reset) begin
            r_ir[r_tail]  <= imem_data;
            r_pc2[r_tail] <= w_fpc_inc;
        end
    end

    assign out_valid   = w_nonempty;
    assign out_ir      = w_nonempty ? r_ir[r_head]  : 16'h0000;
    assign out_pcplus2 = w_nonempty ? r_pc2[r_head] : 16'h0000;
    assign count       = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          imem_req;
    logic [15:0]   imem_addr;
    logic [15:0]   imem_data = 16'h0000;
    logic          imem_valid = 1'b0;
    logic          redirect = 1'b0;
    logic [15:0]   redirect_pc = 16'h0000;
    logic          deq = 1'b0;
    logic [15:0]   out_ir;
    logic [15:0]   out_pcplus2;
    logic          out_valid;
    logic [CW-1:0] count;

    fetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .imem_valid  (imem_valid),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .deq         (deq),
        .out_ir      (out_ir),
        .out_pcplus2 (out_pcplus2),
        .out_valid   (out_valid),
        .count       (count)
    );

    always #5 clock = ~clock;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // Memory: pending responses with their due cycle.
    typedef struct { logic [15:0] addr; int due; } mreq_t;
    mreq_t mq[$];
    int lat      = 1;
    bit lat_rand = 0;

    // Reference model: queue contents, fetch PC, and whether a request is out / must be dropped.
    typedef struct { logic [15:0] ir; logic [15:0] pc2; } ent_t;
    ent_t        m_q[$];
    logic [15:0] m_fpc     = 16'h0000;
    bit          m_pending = 0;
    bit          m_stale   = 0;

    bit          in_reset = 1, in_redirect = 0, in_deq = 0;
    logic [15:0] in_rpc = 16'h0000;

    logic          s_req, s_valid, s_vin;
    logic [15:0]   s_addr, s_ir, s_pc2, s_data;
    logic [CW-1:0] s_cnt;

    typedef struct {
        bit rst; bit dq; bit e_req; logic [15:0] e_addr; int e_cnt;
        logic [15:0] e_ir; logic [15:0] e_pc2; bit e_valid;
    } vec_t;
    vec_t tbl[16];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h8100;
            16'h0002: return 16'h8202;
            16'h0004: return 16'h0000;
            16'h0006: return 16'h6600;
            default:  return {a[7:0], a[15:8]} ^ 16'h1357;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        bit          resp, push, dq_ok, e_req;
        int          sz;
        logic [15:0] e_addr;
        reset       = in_reset;
        redirect    = in_redirect;
        redirect_pc = in_rpc;
        deq         = in_deq;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_valid = 1'b1;
            imem_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_valid = 1'b0;
            imem_data  = 16'($urandom);
        end
        s_vin  = imem_valid;
        s_data = imem_data;
        @(posedge clock);
        s_req = imem_req; s_addr = imem_addr; s_cnt = count;
        s_ir = out_ir; s_pc2 = out_pcplus2; s_valid = out_valid;

        sz = m_q.size();
        check("count", 32'(s_cnt), sz);
        check("out_valid", 32'(s_valid), 32'(sz != 0));
        check("out_ir", 32'(s_ir), (sz != 0) ? 32'(m_q[0].ir) : 32'h0);
        check("out_pcplus2", 32'(s_pc2), (sz != 0) ? 32'(m_q[0].pc2) : 32'h0);

        dq_ok = in_deq && sz > 0 && !in_redirect && !in_reset;
        resp  = m_pending && s_vin;
        push  = resp && !m_stale && !in_redirect && !in_reset;
        if (in_reset || in_redirect)  e_req = 0;
        else if (!m_pending)          e_req = (sz < DEPTH);
        else if (push)                e_req = ((sz + 1 - int'(dq_ok)) < DEPTH);
        else                          e_req = 0;
        e_addr = push ? m_fpc + 16'd2 : m_fpc;
        check("imem_req", 32'(s_req), 32'(e_req));
        if (e_req && s_req) check("imem_addr", 32'(s_addr), 32'(e_addr));

        if (s_req) begin
            check("one_outstanding", mq.size(), 0);
            mq.push_back('{imem_addr, cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat)});
        end

        @(negedge clock);
        if (in_reset) begin
            m_q.delete(); m_fpc = 16'h0000; m_pending = 0; m_stale = 0;
        end else if (in_redirect) begin
            m_q.delete();
            m_fpc = in_rpc & 16'hFFFE;
            if (resp) begin m_pending = 0; m_stale = 0; end
            else if (m_pending) m_stale = 1;
        end else begin
            if (dq_ok) void'(m_q.pop_front());
            if (push) begin
                check("push_not_full", 32'(m_q.size() < DEPTH), 1);
                m_q.push_back('{s_data, m_fpc + 16'd2});
                m_fpc = m_fpc + 16'd2;
            end
            if (resp) begin m_pending = 0; m_stale = 0; end
            if (e_req) m_pending = 1;
        end
        #1;
        cyc++;
    endtask

    task automatic reset_hold(input int n);
        in_reset = 1; in_redirect = 0; in_deq = 0;
        repeat (n) step();
        in_reset = 0;
    endtask

    task automatic wait_req(input string name);
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (s_req) ok = 1;
        end
        check({name, "_seen"}, 32'(ok), 1);
    endtask

    task automatic wait_valid(input string name);
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (s_valid) ok = 1;
        end
        check({name, "_seen"}, 32'(ok), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Sequential fill with L=1, then drain with deq held for 6 cycles.
        tbl[0]  = '{1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0};
        tbl[1]  = '{1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0};
        tbl[2]  = '{0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0};
        tbl[3]  = '{0, 0, 1, 16'h0002, 0, 16'h0000, 16'h0000, 0};
        tbl[4]  = '{0, 0, 1, 16'h0004, 1, 16'h8100, 16'h0002, 1};
        tbl[5]  = '{0, 0, 1, 16'h0006, 2, 16'h8100, 16'h0002, 1};
        tbl[6]  = '{0, 0, 0, 16'h0000, 3, 16'h8100, 16'h0002, 1};
        tbl[7]  = '{0, 0, 0, 16'h0000, 4, 16'h8100, 16'h0002, 1};
        tbl[8]  = '{0, 0, 0, 16'h0000, 4, 16'h8100, 16'h0002, 1};
        tbl[9]  = '{0, 1, 0, 16'h0000, 4, 16'h8100, 16'h0002, 1};
        tbl[10] = '{0, 1, 1, 16'h0008, 3, 16'h8202, 16'h0004, 1};
        tbl[11] = '{0, 1, 1, 16'h000A, 2, 16'h0000, 16'h0006, 1};
        tbl[12] = '{0, 1, 1, 16'h000C, 2, 16'h6600, 16'h0008, 1};
        tbl[13] = '{0, 1, 1, 16'h000E, 2, mem_word(16'h0008), 16'h000A, 1};
        tbl[14] = '{0, 1, 1, 16'h0010, 2, mem_word(16'h000A), 16'h000C, 1};
        tbl[15] = '{0, 0, 1, 16'h0012, 2, mem_word(16'h000C), 16'h000E, 1};

        @(negedge clock);
        #1;
        lat = 1; lat_rand = 0;
        for (int i = 0; i < 16; i++) begin
            in_reset = tbl[i].rst; in_deq = tbl[i].dq; in_redirect = 0;
            step();
            check("tbl_req", 32'(s_req), 32'(tbl[i].e_req));
            if (tbl[i].e_req) check("tbl_addr", 32'(s_addr), 32'(tbl[i].e_addr));
            check("tbl_count", 32'(s_cnt), tbl[i].e_cnt);
            check("tbl_ir", 32'(s_ir), 32'(tbl[i].e_ir));
            check("tbl_pc2", 32'(s_pc2), 32'(tbl[i].e_pc2));
            check("tbl_valid", 32'(s_valid), 32'(tbl[i].e_valid));
        end

        // Redirect one cycle after a request, L=3: stale response dropped, refetch at 0x001E.
        lat = 3;
        reset_hold(5);
        wait_req("A_req");
        in_redirect = 1; in_rpc = 16'h001F;
        step();
        in_redirect = 0;
        wait_req("A_rereq");
        check("A_target_addr", 32'(s_addr), 32'h001E);
        wait_valid("A_first");
        check("A_first_pc2", 32'(s_pc2), 32'h0020);
        check("A_first_ir", 32'(s_ir), 32'(mem_word(16'h001E)));

        // Redirect in the same cycle as imem_valid, L=2: no push, target requested next cycle.
        lat = 2;
        reset_hold(5);
        wait_req("B_req");
        step();
        in_redirect = 1; in_rpc = 16'h0040;
        step();
        check("B_valid_coincides", 32'(s_vin), 1);
        in_redirect = 0;
        step();
        check("B_req", 32'(s_req), 1);
        check("B_addr", 32'(s_addr), 32'h0040);
        check("B_empty", 32'(s_cnt), 0);

        // Wrap: fetch 0xFFFE then 0x0000; the 0xFFFE entry carries pcplus2 = 0.
        lat = 1; in_deq = 1;
        in_redirect = 1; in_rpc = 16'hFFFF;
        step();
        in_redirect = 0;
        wait_req("C_req");
        check("C_addr_fffe", 32'(s_addr), 32'hFFFE);
        wait_req("C_wrap");
        check("C_addr_0000", 32'(s_addr), 32'h0000);
        wait_valid("C_head");
        check("C_head_pc2", 32'(s_pc2), 32'h0000);
        check("C_head_ir", 32'(s_ir), 32'(mem_word(16'hFFFE)));

        // Reset mid-WAIT: outputs return to 0 and fetch restarts at 0.
        in_deq = 0; lat = 3;
        wait_req("D_req");
        step();
        reset_hold(4);
        check("D_rst_valid", 32'(s_valid), 0);
        check("D_rst_ir", 32'(s_ir), 0);
        check("D_rst_pc2", 32'(s_pc2), 0);
        check("D_rst_count", 32'(s_cnt), 0);
        check("D_rst_req", 32'(s_req), 0);
        wait_req("D_restart");
        check("D_restart_addr", 32'(s_addr), 32'h0000);

        // Randomized traffic with per-request latency 1..4.
        lat_rand = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                reset_hold(5);
            end else begin
                in_deq      = 1'($urandom_range(0, 1));
                in_redirect = ($urandom_range(0, 19) == 0);
                in_rpc      = 16'($urandom);
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
